ram_loader: RTL and testbench

RAM_LOADER -- requirements
Module: ram_loader

---
 rtl/ram_loader.sv | 189 ++++++++++++++++++
 tb/tb_ram_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_loader.sv
// Streams a length-prefixed big-endian word image into CPU RAM, then releases CPU reset.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module ram_loader #(
    parameter logic [12:0] BASE_ADDR = 13'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic [7:0]  i_byte,
    input  logic        i_byte_valid,
    output logic        o_byte_ready,
    output logic [12:0] o_ram_addr,
    output logic [31:0] o_ram_wdata,
    output logic        o_ram_wen,
    output logic        o_cpu_reset,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [13:0] o_word_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
`ifdef LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [15:0] len_q, len_d;
    logic [23:0] shreg_q, shreg_d;
    logic [1:0]  idx_q, idx_d;
    logic [13:0] cnt_q, cnt_d;
    logic [12:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    logic        accept;
    logic        start_go;
    logic [15:0] len_full;
    logic        last_word;
    state_e      fin_state;

    assign accept    = i_byte_valid & o_byte_ready;
    assign start_go  = i_start & ((state_q == S_IDLE) | (state_q == S_DONE));
    assign len_full  = {len_q[15:8], i_byte};
    assign last_word = ({2'b00, cnt_q} + 16'd1) == len_q;
`ifdef LOADER_CHECKSUM_EN
    assign fin_state = S_CSUM;
`else
    assign fin_state = S_DONE;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (i_start) state_d = S_LEN_HI;
            S_LEN_HI: if (accept) state_d = S_LEN_LO;
            S_LEN_LO: begin
                if (accept) begin
                    if (len_full == 16'd0)        state_d = fin_state;
                    else if (len_full > 16'd8192) state_d = S_DONE;
                    else                          state_d = S_DATA;
                end
            end
            S_DATA:   if (accept && idx_q == 2'd3) state_d = S_WRITE;
            S_WRITE:  state_d = last_word ? fin_state : S_DATA;
`ifdef LOADER_CHECKSUM_EN
            S_CSUM:   if (accept) state_d = S_DONE;
`endif
            S_DONE:   if (i_start) state_d = S_LEN_HI;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_byte_ready = 1'b0;
        o_ram_wen    = 1'b0;
        o_busy       = 1'b1;
        o_done       = 1'b0;
        unique case (state_q)
            S_IDLE:   o_busy = 1'b0;
            S_LEN_HI,
            S_LEN_LO,
            S_DATA:   o_byte_ready = 1'b1;
            S_WRITE:  o_ram_wen = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            S_CSUM:   o_byte_ready = 1'b1;
`endif
            S_DONE: begin
                o_busy = 1'b0;
                o_done = 1'b1;
            end
            default:  o_busy = 1'b0;
        endcase
    end

    assign o_cpu_reset = (state_q == S_DONE) & ~err_q;
    assign o_err       = err_q;
    assign o_word_cnt  = cnt_q;
    assign o_ram_addr  = addr_q;
    assign o_ram_wdata = wdata_q;

    // Address/data are captured on the fourth byte so they are stable for the whole WRITE cycle.
    always_comb begin
        len_d   = len_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        if (start_go) begin
            cnt_d  = '0;
            idx_d  = '0;
            err_d  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_d = '0;
`endif
        end
        if (accept && state_q == S_LEN_HI) len_d = {i_byte, 8'h00};
        if (accept && state_q == S_LEN_LO) begin
            len_d = len_full;
            if (len_full > 16'd8192) err_d = 1'b1;
        end
        if (accept && state_q == S_DATA) begin
            shreg_d = {shreg_q[15:0], i_byte};
            idx_d   = idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            csum_d  = csum_q ^ i_byte;
`endif
            if (idx_q == 2'd3) begin
                addr_d  = BASE_ADDR + cnt_q[12:0];
                wdata_d = {shreg_q, i_byte};
            end
        end
        if (state_q == S_WRITE) cnt_d = cnt_q + 14'd1;
`ifdef LOADER_CHECKSUM_EN
        if (accept && state_q == S_CSUM && i_byte != csum_q) err_d = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q   <= '0;
            shreg_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            len_q   <= len_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_ram_loader.sv
// Randomised scoreboard bench for ram_loader; two instances (base 0 and base 8191) share one stream.
module tb_ram_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_start = 1'b0;
    logic [7:0]  i_byte = 8'h00;
    logic        i_byte_valid = 1'b0;

    logic        rdy0, wen0, cpu0, busy0, done0, err0;
    logic [12:0] addr0;
    logic [31:0] wd0;
    logic [13:0] cnt0;
    logic        rdy1, wen1, cpu1, busy1, done1, err1;
    logic [12:0] addr1;
    logic [31:0] wd1;
    logic [13:0] cnt1;

    ram_loader #(.BASE_ADDR(13'd0)) dut0 (
        .clk(clk), .reset(reset), .i_start(i_start), .i_byte(i_byte),
        .i_byte_valid(i_byte_valid), .o_byte_ready(rdy0),
        .o_ram_addr(addr0), .o_ram_wdata(wd0), .o_ram_wen(wen0),
        .o_cpu_reset(cpu0), .o_busy(busy0), .o_done(done0),
        .o_err(err0), .o_word_cnt(cnt0)
    );

    ram_loader #(.BASE_ADDR(13'd8191)) dut1 (
        .clk(clk), .reset(reset), .i_start(i_start), .i_byte(i_byte),
        .i_byte_valid(i_byte_valid), .o_byte_ready(rdy1),
        .o_ram_addr(addr1), .o_ram_wdata(wd1), .o_ram_wen(wen1),
        .o_cpu_reset(cpu1), .o_busy(busy1), .o_done(done1),
        .o_err(err1), .o_word_cnt(cnt1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t q0[$];
    wr_t q1[$];
    int  n_chk = 0;
    int  n_fail = 0;
    bit  tog = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitors: every write pulse must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (wen0) begin
            if (q0.size() == 0) begin
                chk("dut0_unexpected_write", 64'(addr0), 64'h1_0000);
            end else begin
                wr_t e;
                e = q0.pop_front();
                chk("dut0_waddr", 64'(addr0), 64'(e.addr));
                chk("dut0_wdata", 64'(wd0), 64'(e.data));
            end
        end
    end

    always @(negedge clk) begin
        if (wen1) begin
            if (q1.size() == 0) begin
                chk("dut1_unexpected_write", 64'(addr1), 64'h1_0000);
            end else begin
                wr_t e;
                e = q1.pop_front();
                chk("dut1_waddr", 64'(addr1), 64'(e.addr));
                chk("dut1_wdata", 64'(wd1), 64'(e.data));
            end
        end
    end

    // gap: 0 = none, 1 = random idle cycles (with stray i_start), 2 = strict 1/0 alternation
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit idle;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            idle = (gap == 1) ? ($urandom_range(0, 2) == 0) : (gap == 2) ? tog : 1'b0;
            tog = ~tog;
            if (idle) begin
                i_byte_valid = 1'b0;
                i_byte = 8'($urandom);
                i_start = 1'($urandom_range(0, 1));
            end else begin
                i_start = 1'b0;
                i_byte = b;
                i_byte_valid = 1'b1;
                if (rdy0) begin
                    @(posedge clk);
                    return;
                end
            end
        end
        chk("byte_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        i_byte_valid = 1'b0;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk("start_busy", 64'(busy0), 64'd1);
        chk("start_cpu_reset", 64'(cpu0), 64'd0);
        chk("start_done", 64'(done0), 64'd0);
        chk("start_cnt", 64'(cnt0), 64'd0);
    endtask

    task automatic load(input logic [15:0] n, input logic [31:0] w[], input int gap, input bit bad_cs);
        logic [7:0] cs;
        bit         exp_err;
        int         exp_cnt;
        bit         got;
        cs = 8'h00;
        exp_err = (n > 16'd8192);
        exp_cnt = exp_err ? 0 : int'(n);
        pulse_start();
        send_byte(n[15:8], gap);
        send_byte(n[7:0], gap);
        if (!exp_err) begin
            for (int i = 0; i < int'(n); i++) begin
                q0.push_back('{addr: (0 + i) % 8192, data: w[i]});
                q1.push_back('{addr: (8191 + i) % 8192, data: w[i]});
                for (int k = 3; k >= 0; k--) begin
                    logic [31:0] word;
                    word = w[i];
                    cs ^= word[k*8 +: 8];
                    send_byte(word[k*8 +: 8], gap);
                end
            end
`ifdef LOADER_CHECKSUM_EN
            send_byte(bad_cs ? (cs ^ 8'h5A) : cs, gap);
            exp_err = bad_cs;
`endif
        end
        got = 1'b0;
        for (int t = 0; t < 300 && !got; t++) begin
            @(negedge clk);
            i_byte_valid = 1'b0;
            i_start = 1'b0;
            got = done0;
        end
        chk("done_seen", 64'(got), 64'd1);
        chk("done0", 64'(done0), 64'd1);
        chk("done1", 64'(done1), 64'd1);
        chk("busy_after", 64'(busy0), 64'd0);
        chk("err0", 64'(err0), 64'(exp_err));
        chk("cpu_reset0", 64'(cpu0), 64'(!exp_err));
        chk("cpu_reset1", 64'(cpu1), 64'(!exp_err));
        chk("word_cnt0", 64'(cnt0), 64'(exp_cnt));
        chk("word_cnt1", 64'(cnt1), 64'(exp_cnt));
        chk("q0_drained", 64'(q0.size()), 64'd0);
        chk("q1_drained", 64'(q1.size()), 64'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, 64'(rdy0), 64'd0);
        chk({tag, "_addr"}, 64'(addr0), 64'd0);
        chk({tag, "_wdata"}, 64'(wd0), 64'd0);
        chk({tag, "_wen"}, 64'(wen0), 64'd0);
        chk({tag, "_cpu_reset"}, 64'(cpu0), 64'd0);
        chk({tag, "_busy"}, 64'(busy0), 64'd0);
        chk({tag, "_done"}, 64'(done0), 64'd0);
        chk({tag, "_err"}, 64'(err0), 64'd0);
        chk({tag, "_cnt"}, 64'(cnt0), 64'd0);
    endtask

    initial begin
        logic [31:0] w[];
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready", 64'(rdy0), 64'd0);

        w = new[2];
        w[0] = 32'hDEADBEEF;
        w[1] = 32'h01020304;
        load(16'd2, w, 0, 1'b0);

        w = new[1];
        w[0] = 32'h11223344;
        load(16'd1, w, 2, 1'b0);

        w = new[0];
        load(16'h2001, w, 1, 1'b0);
        load(16'h0000, w, 0, 1'b0);

        // Abort after two data bytes, then reload.
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_vals("mid_data");
        @(negedge clk);
        reset = 1'b1;
        i_byte_valid = 1'b0;
        w = new[1];
        w[0] = 32'hAABBCCDD;
        load(16'd1, w, 0, 1'b0);

        // Reset landing inside the WRITE cycle must kill the pulse at once.
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        send_byte(8'h77, 0);
        send_byte(8'h88, 0);
        #1;
        chk("write_pulse_up", 64'(wen0), 64'd1);
        chk("write_addr_live", 64'(addr0), 64'd0);
        reset = 1'b0;
        #1;
        chk("write_pulse_killed", 64'(wen0), 64'd0);
        chk("write_pulse_killed1", 64'(wen1), 64'd0);
        check_reset_vals("mid_write");
        @(negedge clk);
        reset = 1'b1;
        i_byte_valid = 1'b0;

        w = new[2];
        w[0] = 32'hCAFEF00D;
        w[1] = 32'h0BADC0DE;
        load(16'd2, w, 1, 1'b1);

        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(1, 6);
            w = new[n];
            foreach (w[i]) w[i] = $urandom;
            load(16'(n), w, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
